trap_flush_unit: RTL
====================

TRAP_FLUSH_UNIT -- requirements
Module: trap_flush_unit

Interface
REQ-001 Parameter XLEN, default 32: PC and vector width.
REQ-002 Parameter NSTAGE, default 5, legal range 3..8: pipeline depth; index 0 = fetch (youngest), NSTAGE-1 = writeback (oldest).
REQ-003 Parameter DRAIN_MAX, default 15: drain timeout in cycles, legal range 1..255.
REQ-004 Port clk, input, 1: clock, rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Ports stage_valid, stage_exc, input, NSTAGE each: per-stage valid and exception request.
REQ-007 Ports stage_pc, stage_exc_vec, input, NSTAGE*XLEN each: per-stage PC and exception vector; stage i occupies bits [i*XLEN +: XLEN].
REQ-008 Ports irq_pending, irq_enable and stall, input, 1 each; port irq_vector, input, XLEN.
REQ-009 Port flush, output, NSTAGE: per-stage kill mask.
REQ-010 Ports hold_fetch, pc_redirect, busy, irq_taken, exc_taken and drain_timeout, output, 1 each.
REQ-011 Ports redirect_pc and mepc, output, XLEN each; port trap_is_irq, output, 1.

Function
REQ-012 States: IDLE, DRAIN and TRAP; busy is 1 in any state other than IDLE.
REQ-013 Winning exception: the highest index k with stage_valid[k] and stage_exc[k] both set.
REQ-014 Exception response in IDLE or DRAIN is combinational, same cycle: flush[0..k]=1 and flush[k+1..]=0; pc_redirect=1; redirect_pc=stage_exc_vec[k]; exc_taken=1.
REQ-015 mepc and trap_is_irq are registered: at the next edge, mepc<=stage_pc[k] and trap_is_irq<=0; the state goes to IDLE.
REQ-016 An exception in DRAIN abandons the interrupt; irq_pending is not consumed.
REQ-017 IDLE->DRAIN when irq_pending, irq_enable, !stall and no exception are all true: irq_vector is latched, mepc<=stage_pc[0], and drain_cnt<=0.
REQ-018 In DRAIN: hold_fetch=1 and flush[0]=1; drain_cnt increments each cycle and saturates.
REQ-019 In DRAIN, whenever stage_valid[NSTAGE-1]=1, mepc<=stage_pc[NSTAGE-1]+4, with modulo 2^XLEN wrap.
REQ-020 DRAIN->TRAP when stage_valid[1..NSTAGE-2] are all 0.
REQ-021 DRAIN->TRAP also when drain_cnt==DRAIN_MAX (timeout): mepc<=stage_pc of the oldest valid stage in 1..NSTAGE-2, and drain_timeout pulses for one cycle.
REQ-022 DRAIN->IDLE when irq_enable falls (abort): hold_fetch is released, and no trap outputs or mepc update occur.
REQ-023 TRAP lasts exactly one cycle: flush[0..NSTAGE-2]=1, flush[NSTAGE-1]=0, pc_redirect=1, redirect_pc=latched vector, irq_taken=1 and trap_is_irq=1.
REQ-024 TRAP->IDLE unconditionally; a new interrupt is not accepted until the following cycle.
REQ-025 stall blocks interrupt entry only; it never blocks or delays exceptions.
REQ-026 Outside the cases above, flush=0 and pc_redirect, irq_taken and exc_taken are 0.

Reset
REQ-027 Asserting rst_n low sets state=IDLE, drain_cnt=0, mepc=0, trap_is_irq=0 and the latched vector=0 immediately, including mid-DRAIN.
REQ-028 While rst_n is low all combinational outputs read 0.

Configuration
REQ-029 Macro TFU_TRAP_COUNT_EN defined: adds outputs irq_count and exc_count, 16 bits each, reset 0; each increments on irq_taken or exc_taken respectively and saturates at 0xFFFF.
REQ-030 Macro TFU_TRAP_COUNT_EN undefined: irq_count and exc_count ports and their logic are absent; all other behaviour is identical.

Verification
REQ-031 NSTAGE=5, stage_valid=5'b11111, stage_exc[3]=1 with vec 0x100, stage_exc[1]=1 -> same cycle flush=5'b01111, redirect_pc=0x100, exc_taken=1; next cycle mepc=stage_pc[3].
REQ-032 irq_pending=1, irq_enable=1, vector 0x200, stage 4 retires pc 0x40, stages 1-3 empty after 3 cycles -> DRAIN for 3 cycles with hold_fetch=1, then TRAP with irq_taken=1, redirect_pc=0x200, mepc=0x44, flush=5'b01111.
REQ-033 DRAIN_MAX=4 and stage 2 held valid at pc 0x80 -> drain_timeout=1 on the 5th DRAIN cycle, TRAP next cycle, mepc=0x80.
REQ-034 stage_exc[2] asserted on the 2nd DRAIN cycle -> exc_taken=1 and flush=5'b00111 that cycle, no irq_taken, then IDLE; irq re-enters DRAIN one cycle later.
REQ-035 irq_enable drops mid-DRAIN -> IDLE next cycle, hold_fetch=0, and no pc_redirect.
REQ-036 rst_n pulsed low mid-DRAIN -> busy=0 and mepc=0 immediately; with TFU_TRAP_COUNT_EN defined, counters read 0.

Source files
------------

// File: rtl/trap_flush_unit.sv
// Trap/flush controller: precise exceptions, interrupt drain and trap entry.
// Optional trap counters are enabled by defining TFU_TRAP_COUNT_EN.
module trap_flush_unit #(
  parameter int XLEN      = 32,
  parameter int NSTAGE    = 5,
  parameter int DRAIN_MAX = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NSTAGE-1:0]      stage_valid,
  input  logic [NSTAGE-1:0]      stage_exc,
  input  logic [NSTAGE*XLEN-1:0] stage_pc,
  input  logic [NSTAGE*XLEN-1:0] stage_exc_vec,
  input  logic                   irq_pending,
  input  logic                   irq_enable,
  input  logic                   stall,
  input  logic [XLEN-1:0]        irq_vector,
  output logic [NSTAGE-1:0]      flush,
  output logic                   hold_fetch,
  output logic                   pc_redirect,
  output logic                   busy,
  output logic                   irq_taken,
  output logic                   exc_taken,
  output logic                   drain_timeout,
  output logic [XLEN-1:0]        redirect_pc,
  output logic [XLEN-1:0]        mepc,
  output logic                   trap_is_irq
`ifdef TFU_TRAP_COUNT_EN
  ,
  output logic [15:0]            irq_count,
  output logic [15:0]            exc_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [7:0]        drain_cnt_r, drain_cnt_nxt_s;
  logic [XLEN-1:0]   mepc_r, mepc_nxt_s;
  logic [XLEN-1:0]   vec_r, vec_nxt_s;
  logic              trap_is_irq_r, trap_is_irq_nxt_s;

  logic [NSTAGE-1:0] exc_req_s;
  logic [NSTAGE-1:0] exc_mask_s;
  logic              exc_hit_s;
  logic              take_exc_s;
  logic [XLEN-1:0]   exc_pc_s;
  logic [XLEN-1:0]   exc_vec_s;
  logic              mid_busy_s;
  logic [XLEN-1:0]   mid_pc_s;

  assign exc_req_s  = stage_valid & stage_exc;
  assign exc_hit_s  = |exc_req_s;
  assign take_exc_s = exc_hit_s && (state_r != ST_TRAP);
  assign mid_busy_s = |stage_valid[NSTAGE-2:1];

  // Oldest excepting stage wins; the kill mask covers it and everything younger.
  always_comb begin
    exc_pc_s   = '0;
    exc_vec_s  = '0;
    exc_mask_s = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      exc_pc_s  = exc_req_s[i] ? stage_pc[i*XLEN +: XLEN]      : exc_pc_s;
      exc_vec_s = exc_req_s[i] ? stage_exc_vec[i*XLEN +: XLEN] : exc_vec_s;
    end
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      exc_mask_s[i] = exc_req_s[i] | ((i < NSTAGE - 1) ? exc_mask_s[i+1] : 1'b0);
    end
  end

  // Resume point on drain timeout: oldest instruction still in flight mid-pipe.
  always_comb begin
    mid_pc_s = '0;
    for (int i = 1; i < NSTAGE - 1; i++) begin
      mid_pc_s = stage_valid[i] ? stage_pc[i*XLEN +: XLEN] : mid_pc_s;
    end
  end

  // Next-state and output decode; everything reads 0 while reset is held.
  always_comb begin
    flush             = '0;
    hold_fetch        = 1'b0;
    pc_redirect       = 1'b0;
    redirect_pc       = '0;
    busy              = 1'b0;
    irq_taken         = 1'b0;
    exc_taken         = 1'b0;
    drain_timeout     = 1'b0;
    state_nxt_s       = state_r;
    drain_cnt_nxt_s   = drain_cnt_r;
    mepc_nxt_s        = mepc_r;
    vec_nxt_s         = vec_r;
    trap_is_irq_nxt_s = trap_is_irq_r;
    if (!rst_n) begin
      state_nxt_s = ST_IDLE;
    end else if (take_exc_s) begin
      // Exceptions preempt both idle and an in-progress interrupt drain.
      busy              = (state_r != ST_IDLE);
      hold_fetch        = (state_r == ST_DRAIN);
      flush             = exc_mask_s;
      pc_redirect       = 1'b1;
      redirect_pc       = exc_vec_s;
      exc_taken         = 1'b1;
      mepc_nxt_s        = exc_pc_s;
      trap_is_irq_nxt_s = 1'b0;
      state_nxt_s       = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (irq_pending && irq_enable && !stall) begin
            state_nxt_s     = ST_DRAIN;
            vec_nxt_s       = irq_vector;
            mepc_nxt_s      = stage_pc[XLEN-1:0];
            drain_cnt_nxt_s = 8'd0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_DRAIN: begin
          busy            = 1'b1;
          hold_fetch      = 1'b1;
          flush[0]        = 1'b1;
          drain_cnt_nxt_s = (drain_cnt_r == 8'hFF) ? drain_cnt_r : drain_cnt_r + 8'd1;
          if (!irq_enable) begin
            state_nxt_s = ST_IDLE;
          end else begin
            if (stage_valid[NSTAGE-1]) begin
              mepc_nxt_s = stage_pc[(NSTAGE-1)*XLEN +: XLEN] + XLEN'(32'd4);
            end else begin
              mepc_nxt_s = mepc_r;
            end
            if (!mid_busy_s) begin
              state_nxt_s       = ST_TRAP;
              trap_is_irq_nxt_s = 1'b1;
            end else if (drain_cnt_r == 8'(DRAIN_MAX)) begin
              drain_timeout     = 1'b1;
              mepc_nxt_s        = mid_pc_s;
              state_nxt_s       = ST_TRAP;
              trap_is_irq_nxt_s = 1'b1;
            end else begin
              state_nxt_s = ST_DRAIN;
            end
          end
        end
        ST_TRAP: begin
          busy        = 1'b1;
          flush       = {1'b0, {(NSTAGE-1){1'b1}}};
          pc_redirect = 1'b1;
          redirect_pc = vec_r;
          irq_taken   = 1'b1;
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and trap context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      drain_cnt_r   <= 8'd0;
      mepc_r        <= '0;
      vec_r         <= '0;
      trap_is_irq_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      drain_cnt_r   <= drain_cnt_nxt_s;
      mepc_r        <= mepc_nxt_s;
      vec_r         <= vec_nxt_s;
      trap_is_irq_r <= trap_is_irq_nxt_s;
    end
  end

  assign mepc        = mepc_r;
  assign trap_is_irq = trap_is_irq_r;

`ifdef TFU_TRAP_COUNT_EN
  // Saturating trap event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_count <= 16'd0;
      exc_count <= 16'd0;
    end else begin
      if (irq_taken && (irq_count != 16'hFFFF)) begin
        irq_count <= irq_count + 16'd1;
      end else begin
        irq_count <= irq_count;
      end
      if (exc_taken && (exc_count != 16'hFFFF)) begin
        exc_count <= exc_count + 16'd1;
      end else begin
        exc_count <= exc_count;
      end
    end
  end
`endif

endmodule
